// File: rtl/reg_mw.sv
// ME/WB pipeline register: captures the ME result, extracts big-endian load data,
// flags misaligned loads and counts retired instructions.
module reg_mw #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_me,
  input  logic             wreg_me,
  input  logic             m2reg_me,
  input  logic [2:0]       ld_type_me,
  input  logic [4:0]       rn_me,
  input  logic [31:0]      addr,
  input  logic [31:0]      mo_me,
  output logic             valid_wb,
  output logic             wreg_wb,
  output logic [4:0]       rn_wb,
  output logic [31:0]      wdi_wb,
  output logic             misalign_wb,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } ld_type_e;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_val;
  logic [31:0] wdi_next;
  logic        mis_addr;
  logic        misalign;
  logic        wreg_next;

  always_comb begin
    byte_sel = '0;
    case (addr[1:0])
      2'd0: byte_sel = mo_me[31:24];
      2'd1: byte_sel = mo_me[23:16];
      2'd2: byte_sel = mo_me[15:8];
      default: byte_sel = mo_me[7:0];
    endcase
    half_sel = addr[1] ? mo_me[15:0] : mo_me[31:16];

    // Unlisted encodings fall through to word behaviour, including alignment.
    ld_val   = mo_me;
    mis_addr = |addr[1:0];
    case (ld_type_me)
      LD_B: begin
        ld_val   = {{24{byte_sel[7]}}, byte_sel};
        mis_addr = 1'b0;
      end
      LD_BU: begin
        ld_val   = {24'd0, byte_sel};
        mis_addr = 1'b0;
      end
      LD_H: begin
        ld_val   = {{16{half_sel[15]}}, half_sel};
        mis_addr = addr[0];
      end
      LD_HU: begin
        ld_val   = {16'd0, half_sel};
        mis_addr = addr[0];
      end
      default: begin
        ld_val   = mo_me;
        mis_addr = |addr[1:0];
      end
    endcase

    misalign  = valid_me & m2reg_me & mis_addr;
    wdi_next  = misalign ? '0 : (m2reg_me ? ld_val : addr);
    wreg_next = valid_me & wreg_me & ~misalign;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_wb    <= 1'b0;
      wreg_wb     <= 1'b0;
      rn_wb       <= '0;
      wdi_wb      <= '0;
      misalign_wb <= 1'b0;
      retired     <= '0;
    end else if (flush) begin
      valid_wb    <= 1'b0;
      wreg_wb     <= 1'b0;
      rn_wb       <= '0;
      wdi_wb      <= '0;
      misalign_wb <= 1'b0;
    end else if (!stall) begin
      valid_wb    <= valid_me;
      wreg_wb     <= wreg_next;
      rn_wb       <= rn_me;
      wdi_wb      <= wdi_next;
      misalign_wb <= misalign;
      if (valid_me && !misalign)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule
